// File: rtl/ps2_pkg.sv
// Shared PS/2 types and command constants for the mouse port.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_CMD_STREAM = 8'hEA;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings one raw PS/2 line into the clk domain and flags its falling edges.
// Shared with the receive path.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic edge_p2;

  // Two-flop synchronizer, an edge register, and a registered fall flag.
  // Idle PS/2 lines are high, so the chain resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      edge_p2 <= 1'b1;
      fall    <= 1'b0;
    end else begin
      sync_p0 <= pin;
      sync_p1 <= sync_p0;
      edge_p2 <= sync_p1;
      fall    <= edge_p2 & ~sync_p1;
    end
  end

  assign level = sync_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift out one
// command byte on device clock falls, check the device ACK, with a watchdog.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 65_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int INH_W       = $clog2(INHIBIT_CYC + 1);
  localparam int WD_W        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

  ps2_tx_state_t    state, state_d;
  logic [9:0]       frame, frame_d;
  logic [3:0]       bit_cnt, bit_cnt_d;
  logic [INH_W-1:0] inh_cnt, inh_cnt_d;
  logic [WD_W-1:0]  wd_cnt, wd_cnt_d;
  logic             data_oe_q, data_oe_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic data_fall_unused;

  ps2_sync_edge u_clk_sync (
    .clk   (clk),
    .rst   (rst),
    .pin   (ps2_clk_in),
    .level (clk_level),
    .fall  (clk_fall)
  );

  // The transmitter only needs the data level; the fall flag serves the receive path.
  ps2_sync_edge u_data_sync (
    .clk   (clk),
    .rst   (rst),
    .pin   (ps2_data_in),
    .level (data_level),
    .fall  (data_fall_unused)
  );

  // State and datapath registers; reset releases both lines immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      frame     <= '0;
      bit_cnt   <= '0;
      inh_cnt   <= '0;
      wd_cnt    <= '0;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_d;
      frame     <= frame_d;
      bit_cnt   <= bit_cnt_d;
      inh_cnt   <= inh_cnt_d;
      wd_cnt    <= wd_cnt_d;
      data_oe_q <= data_oe_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: frame sequencing, bit shifting, ACK check and watchdog.
  always_comb begin
    state_d   = state;
    frame_d   = frame;
    bit_cnt_d = bit_cnt;
    inh_cnt_d = inh_cnt;
    wd_cnt_d  = wd_cnt;
    data_oe_d = data_oe_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state)
      IDLE: begin
        data_oe_d = 1'b0;
        if (tx_start) begin
          frame_d   = {1'b1, odd_parity(tx_data), tx_data};
          bit_cnt_d = '0;
          inh_cnt_d = '0;
          wd_cnt_d  = '0;
          ack_d     = 1'b0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          inh_cnt_d = '0;
          state_d   = RTS;
        end else begin
          inh_cnt_d = inh_cnt + 1'b1;
        end
      end
      RTS: begin
        // Start bit: data stays low once the clock is released.
        data_oe_d = 1'b1;
        wd_cnt_d  = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        wd_cnt_d = wd_cnt + 1'b1;
        if (clk_fall) begin
          if (bit_cnt == 4'd10) begin
            // 11th fall: the device should be holding data low as ACK.
            ack_d   = data_level;
            state_d = ACK;
          end else begin
            data_oe_d = ~frame[0];
            frame_d   = {1'b0, frame[9:1]};
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      ACK: begin
        wd_cnt_d = wd_cnt + 1'b1;
        if (!ack_q) begin
          state_d = WAIT_IDLE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_IDLE: begin
        wd_cnt_d = wd_cnt + 1'b1;
        if (clk_level && data_level) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    // Watchdog overrides any completion in the same cycle.
    if ((state == SHIFT || state == ACK || state == WAIT_IDLE) && wd_cnt == WD_LAST) begin
      done_d    = 1'b0;
      err_d     = 1'b1;
      data_oe_d = 1'b0;
      state_d   = IDLE;
    end
  end

  assign ps2_clk_oe  = (state == INHIBIT) || (state == RTS);
  assign ps2_data_oe = (state == RTS) || data_oe_q;
  assign busy        = (state != IDLE);
  assign tx_done     = done_q;
  assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple 10 kHz PS/2 device model.
module tb_ps2_host_tx;

  localparam int TIMEOUT_CYC = 3000;
  localparam logic [10:0] EXP_F4 = 11'b1_0_1111_0100_0;
  localparam logic [10:0] EXP_FF = 11'b1_1_1111_1111_0;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       dev_clk;
  logic       dev_data;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  ps2_host_tx #(
    .CLK_HZ     (1_000_000),
    .INHIBIT_US (100),
    .TIMEOUT_US (3000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err)
  );

  always #5 clk = ~clk;

  // Open-drain wired-AND of host and device.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_err === 1'b1) err_cnt++;
  end

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Device: waits for release after RTS, then clocks n_falls falls,
  // sampling the host data just before each rising edge.
  task automatic dev_receive(input bit do_ack, input int n_falls,
                             output logic [10:0] frame, output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    frame = '1;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      ok = 1'b0;
      return;
    end
    repeat (20) @(negedge clk);
    frame[0] = ps2_data_in;
    for (int i = 1; i <= n_falls; i++) begin
      if (i == 11) begin
        if (do_ack) dev_data = 1'b0;
        dev_clk = 1'b0;
        repeat (50) @(negedge clk);
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        dev_data = 1'b1;
      end else begin
        dev_clk = 1'b0;
        repeat (50) @(negedge clk);
        frame[i] = ps2_data_in;
        dev_clk = 1'b1;
        repeat (50) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_in: got %b expected 00000", {ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_out: got %b expected 00000", {ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err});
    end
  endtask

  task automatic test_send_f4();
    logic [10:0] fr;
    bit ok;
    int n;
    start_tx(8'hF4);
    n_checks++;
    if ({busy, ps2_clk_oe, ps2_data_oe} !== 3'b110) begin
      n_fail++;
      $display("FAIL f4_accept: got %b expected 110", {busy, ps2_clk_oe, ps2_data_oe});
    end
    n = 0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < 500) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (n != 100) begin
      n_fail++;
      $display("FAIL f4_inhibit_len: got %0d expected 100", n);
    end
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b11) begin
      n_fail++;
      $display("FAIL f4_rts: got %b expected 11", {ps2_clk_oe, ps2_data_oe});
    end
    @(negedge clk);
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) begin
      n_fail++;
      $display("FAIL f4_release: got %b expected 01", {ps2_clk_oe, ps2_data_oe});
    end
    dev_receive(1'b1, 11, fr, ok);
    n_checks++;
    if (!ok || fr !== EXP_F4) begin
      n_fail++;
      $display("FAIL f4_frame: got %b ok=%0d expected %b", fr, ok, EXP_F4);
    end
    n = 0;
    while (tx_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if ({tx_done, busy, ps2_clk_oe, ps2_data_oe, tx_err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL f4_done: got %b expected 10000", {tx_done, busy, ps2_clk_oe, ps2_data_oe, tx_err});
    end
  endtask

  // Starts 0xFF in the cycle right after tx_done of the previous frame.
  task automatic test_back_to_back();
    logic [10:0] fr;
    bit ok;
    int n;
    int d0;
    tx_start = 1'b1;
    tx_data  = 8'hFF;
    @(negedge clk);
    tx_start = 1'b0;
    d0 = done_cnt;
    n_checks++;
    if ({busy, ps2_clk_oe, tx_done} !== 3'b110) begin
      n_fail++;
      $display("FAIL b2b_accept: got %b expected 110", {busy, ps2_clk_oe, tx_done});
    end
    dev_receive(1'b1, 11, fr, ok);
    n_checks++;
    if (!ok || fr !== EXP_FF) begin
      n_fail++;
      $display("FAIL ff_frame: got %b ok=%0d expected %b", fr, ok, EXP_FF);
    end
    n = 0;
    while (tx_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    n_checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ff_done: got pulses=%0d busy=%b expected 1 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_no_ack();
    logic [10:0] fr;
    bit ok;
    int d0;
    int e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hEA);
    dev_receive(1'b0, 11, fr, ok);
    repeat (20) @(negedge clk);
    n_checks++;
    if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      n_fail++;
      $display("FAIL noack_pulses: got err=%0d done=%0d expected 1 0", err_cnt - e0, done_cnt - d0);
    end
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL noack_lines: got %b expected 000", {ps2_clk_oe, ps2_data_oe, busy});
    end
  endtask

  task automatic test_watchdog();
    int n;
    int d0;
    int e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hF4);
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (tx_err !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n != TIMEOUT_CYC) begin
      n_fail++;
      $display("FAIL wd_latency: got %0d expected %0d", n, TIMEOUT_CYC);
    end
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL wd_lines: got %b expected 000", {ps2_clk_oe, ps2_data_oe, busy});
    end
    @(negedge clk);
    n_checks++;
    if (tx_err !== 1'b0 || err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      n_fail++;
      $display("FAIL wd_pulse: got err=%b errs=%0d dones=%0d expected 0 1 0", tx_err, err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_ignore_busy();
    logic [10:0] fr;
    bit ok;
    int n;
    int e0;
    e0 = err_cnt;
    start_tx(8'hF4);
    repeat (30) @(negedge clk);
    tx_start = 1'b1;
    tx_data  = 8'h00;
    @(negedge clk);
    tx_start = 1'b0;
    n_checks++;
    if ({busy, ps2_clk_oe, ps2_data_oe} !== 3'b110) begin
      n_fail++;
      $display("FAIL ign_inhibit: got %b expected 110", {busy, ps2_clk_oe, ps2_data_oe});
    end
    fork
      dev_receive(1'b1, 11, fr, ok);
      begin
        repeat (400) @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'h00;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    n_checks++;
    if (!ok || fr !== EXP_F4) begin
      n_fail++;
      $display("FAIL ign_frame: got %b ok=%0d expected %b", fr, ok, EXP_F4);
    end
    n = 0;
    while (tx_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (tx_done !== 1'b1 || err_cnt - e0 != 0) begin
      n_fail++;
      $display("FAIL ign_done: got done=%b errs=%0d expected 1 0", tx_done, err_cnt - e0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [10:0] fr;
    bit ok;
    int n;
    int d0;
    int e0;
    start_tx(8'hF4);
    dev_receive(1'b1, 4, fr, ok);
    n_checks++;
    if ({busy, ps2_data_oe} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_pre: got %b expected 11", {busy, ps2_data_oe});
    end
    d0 = done_cnt;
    e0 = err_cnt;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_async: got %b expected 000", {ps2_clk_oe, ps2_data_oe, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000 || done_cnt != d0 || err_cnt != e0) begin
      n_fail++;
      $display("FAIL rst_after: got %b dones=%0d errs=%0d expected 000 0 0", {ps2_clk_oe, ps2_data_oe, busy}, done_cnt - d0, err_cnt - e0);
    end
    start_tx(8'hF4);
    dev_receive(1'b1, 11, fr, ok);
    n_checks++;
    if (!ok || fr !== EXP_F4) begin
      n_fail++;
      $display("FAIL rst_resend_frame: got %b ok=%0d expected %b", fr, ok, EXP_F4);
    end
    n = 0;
    while (tx_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (tx_done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_resend_done: got done=%b busy=%b expected 1 0", tx_done, busy);
    end
  endtask

  initial begin
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    test_reset();
    test_send_f4();
    test_back_to_back();
    test_no_ack();
    test_watchdog();
    test_ignore_busy();
    test_reset_midframe();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device transmitter for the PS/2 mouse port. It sends one command byte to the mouse, for example 0xF4 (enable data reporting) or 0xFF (reset). It drives the shared open-drain ps2_clk/ps2_data lines through active-high pull-low enables and runs alongside the existing PS/2 receive path inside top_mouse. It performs the inhibit/request-to-send sequence, shifts out data, parity and stop bits on device clock edges, checks the device ACK, and enforces a watchdog.

## Interface
- CLK_HZ, 65_000_000, system clock frequency.
- INHIBIT_US, 100, time ps2_clk is held low before request-to-send.
- TIMEOUT_US, 2000, watchdog from clock release to ACK/idle.
- clk  in  1  system clock. One clock domain; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_start  in  1  single-cycle request. Sampled only in IDLE.
- tx_data  in  8  command byte, captured when tx_start is accepted.
- ps2_clk_in  in  1  raw ps2_clk pin level (asynchronous).
- ps2_data_in  in  1  raw ps2_data pin level (asynchronous).
- ps2_clk_oe  out  1  1 = pull ps2_clk low, 0 = release (top: oe ? 0 : 'z).
- ps2_data_oe  out  1  1 = pull ps2_data low, 0 = release.
- busy  out  1  high from the accept cycle until return to IDLE.
- tx_done  out  1  one-cycle pulse: ACK received, lines idle.
- tx_err  out  1  one-cycle pulse: no ACK, or watchdog expired.

## Operation
- Pin inputs pass through a 2-FF synchronizer plus an edge register. A falling edge (fall) is flagged 3 cycles after the pin falls.
- The transmit frame is {stop=1, parity, D7..D0}, with start=0 driven before bit 0. Parity is odd: ~^tx_data.
- IDLE: oe=00. On tx_start: latch the frame, clear counters, set busy, go to INHIBIT.
- INHIBIT: clk_oe=1 for INHIBIT_CYC = CLK_HZ/1_000_000*INHIBIT_US cycles, then go to RTS.
- RTS: clk_oe=1 and data_oe=1 for exactly one cycle, then go to SHIFT with clk_oe=0 and data_oe=1 (start bit). The watchdog starts.
- SHIFT: on each fall, drive the next frame bit, with data_oe = ~bit. Bits go out in this order: D0..D7, parity, stop. The 10th fall drives stop, which releases data. The next fall moves to ACK.
- ACK: the state is entered on the 11th fall. Sample ps2_data on that fall: 0 goes to WAIT_IDLE; 1 pulses tx_err and goes to IDLE.
- WAIT_IDLE: wait until both synchronized lines are high, then pulse tx_done and go to IDLE.
- Watchdog: TIMEOUT_CYC cycles counted across SHIFT, ACK and WAIT_IDLE. On expiry, pulse tx_err, release both lines, and go to IDLE.
- tx_start while busy is ignored. tx_data is not re-sampled.

## Timing
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_done=0, tx_err=0, state=IDLE, counters=0.
- tx_start at cycle 0 gives busy=1 and clk_oe=1 from cycle 1.
- RTS occupies cycle 1+INHIBIT_CYC. clk_oe=0 from cycle 2+INHIBIT_CYC.
- Data update is registered and appears 4 cycles after the pin falls (3 sync/edge + 1 register).
- tx_done/tx_err rise in the cycle busy falls. A tx_start in the following cycle is accepted.
- Reset mid-frame releases both lines within the same cycle (asynchronous) and discards the frame.
- tx_done and tx_err are mutually exclusive. If the watchdog expires in the same cycle as a final event, tx_err wins.
- Counter widths are $clog2(cycle count + 1). Computing the counts is integer arithmetic on parameters, with no runtime division.

## Structure
- ps2_pkg holds:
  - typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE} ps2_tx_state_t.
  - Constants PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_CMD_STREAM=8'hEA.
- Sub-module ps2_sync_edge (per line: 2-FF synchronizer, level output, fall pulse) is instantiated twice. The receive path reuses it.
- Frame shift register is 10 bits; bit counter is 4 bits.

## Test plan
- Bench parameters: CLK_HZ=1_000_000, INHIBIT_US=100, TIMEOUT_US=3000. Device model clocks at 10 kHz (50 cycles low / 50 cycles high) and ACKs by pulling data low on the 11th falling edge.
- Send 0xF4 -> clk_oe high for exactly 100 cycles, then 1 RTS cycle. Device samples 0,0,0,1,0,1,1,1,1, parity 0, stop 1. ACK -> tx_done pulse, busy 0.
- Send 0xFF -> 8 data ones, parity bit 1, tx_done.
- Device does not drive ACK (data stays high on the 11th fall) -> tx_err single pulse, tx_done never, oe=00.
- Device never clocks after RTS -> tx_err exactly TIMEOUT_CYC=3000 cycles after clock release; lines released.
- tx_start pulses during INHIBIT and SHIFT -> ignored; frame unchanged. Assert rst during bit 4 -> oe=00 the same cycle, busy=0. Then send 0xF4 -> correct frame.
